// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// A W-bit operation is split into STAGES equal slices of slice_w() bits each.
package addsub_pkg;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } addsub_flags_t;

   function automatic int slice_w(input int w, input int stages);
      return (stages > 0) ? (w / stages) : w;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational S-bit slice adder. It also returns the carry into the slice MSB,
// which the last slice uses to derive signed overflow.
module addsub_slice #(
   parameter int S = 4
) (
   input  logic [S-1:0] a,
   input  logic [S-1:0] b,
   input  logic         cin,
   output logic [S-1:0] sum,
   output logic         cout,
   output logic         msb_cin
);

   logic [S:0] full;

   assign full    = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, cin};
   assign sum     = full[S-1:0];
   assign cout    = full[S];
   assign msb_cin = a[S-1] ^ b[S-1] ^ sum[S-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready on both sides.
// Stage k adds slice k; operands, mode and partial sums ride forward with the carry.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int W      = 16,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
   output logic         out_ovf,
   output logic         out_zero,
   output logic         out_neg
);

   localparam int S    = slice_w(W, STAGES);
   localparam int LAST = STAGES - 1;

   if (W < 2 || W > 64 || STAGES < 1 || STAGES > W || (W % STAGES) != 0) begin : g_param_err
      $error("addsub_pipe: illegal W/STAGES combination");
   end

   logic [STAGES-1:0]         valid_q, valid_d;
   logic [STAGES-1:0]         sub_q, sub_d;
   logic [STAGES-1:0]         carry_q, carry_d;
   logic [STAGES-1:0][W-1:0]  a_q, a_d;
   logic [STAGES-1:0][W-1:0]  b_q, b_d;
   logic [STAGES-1:0][W-1:0]  sum_q, sum_d;
   addsub_flags_t             flags_q, flags_d;

   logic [STAGES-1:0]         ready;
   logic [STAGES-1:0]         src_valid, src_sub, src_cin;
   logic [STAGES-1:0][W-1:0]  src_a, src_b, src_sum;
   logic [STAGES-1:0][S-1:0]  sl_a, sl_b, sl_sum;
   logic [STAGES-1:0]         sl_cin, sl_cout, sl_msb_cin;

   // A stage may load when empty or when its occupant leaves this cycle.
   always_comb begin
      logic r;
      r     = out_ready;
      ready = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         r        = !valid_q[i] || r;
         ready[i] = r;
      end
   end

   always_comb begin
      src_valid[0] = in_valid;
      src_a[0]     = in_a;
      src_b[0]     = in_b;
      src_sub[0]   = in_sub;
      src_cin[0]   = in_sub;
      src_sum[0]   = '0;
      for (int k = 1; k < STAGES; k++) begin
         src_valid[k] = valid_q[k-1];
         src_a[k]     = a_q[k-1];
         src_b[k]     = b_q[k-1];
         src_sub[k]   = sub_q[k-1];
         src_cin[k]   = carry_q[k-1];
         src_sum[k]   = sum_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         sl_a[k]   = src_a[k][k*S +: S];
         sl_b[k]   = src_b[k][k*S +: S] ^ {S{src_sub[k] == SUB}};
         sl_cin[k] = src_cin[k];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      addsub_slice #(.S(S)) u_slice (
         .a       (sl_a[k]),
         .b       (sl_b[k]),
         .cin     (sl_cin[k]),
         .sum     (sl_sum[k]),
         .cout    (sl_cout[k]),
         .msb_cin (sl_msb_cin[k])
      );
   end

   always_comb begin
      valid_d = valid_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      flags_d = flags_q;
      for (int k = 0; k < STAGES; k++) begin
         if (ready[k]) begin
            valid_d[k] = src_valid[k];
            if (src_valid[k]) begin
               a_d[k]              = src_a[k];
               b_d[k]              = src_b[k];
               sub_d[k]            = src_sub[k];
               carry_d[k]          = sl_cout[k];
               sum_d[k]            = src_sum[k];
               sum_d[k][k*S +: S]  = sl_sum[k];
            end
         end
      end
      // Flags are registered with the final sum so they read 0 out of reset.
      if (ready[LAST] && src_valid[LAST]) begin
         flags_d.cout = sl_cout[LAST] ^ src_sub[LAST];
         flags_d.ovf  = sl_cout[LAST] ^ sl_msb_cin[LAST];
         flags_d.zero = (sum_d[LAST] == '0);
         flags_d.neg  = sum_d[LAST][W-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         sub_q   <= '0;
         carry_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         flags_q <= '0;
      end else begin
         valid_q <= valid_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         flags_q <= flags_d;
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = valid_q[LAST];
   assign out_sum   = sum_q[LAST];
   assign out_cout  = flags_q.cout;
   assign out_ovf   = flags_q.ovf;
   assign out_zero  = flags_q.zero;
   assign out_neg   = flags_q.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe in three configurations: 8/2, 16/4 and 4/1.
module tb_addsub_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // W=8, STAGES=2
   logic       iv8, ir8, sb8, ov8, or8, c8, o8, z8, n8;
   logic [7:0] a8, b8, s8;
   // W=16, STAGES=4
   logic        iv16, ir16, sb16, ov16, or16, c16, o16, z16, n16;
   logic [15:0] a16, b16, s16;
   // W=4, STAGES=1
   logic       iv4, ir4, sb4, ov4, or4, c4, o4, z4, n4;
   logic [3:0] a4, b4, s4;

   addsub_pipe #(.W(8), .STAGES(2)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
      .in_sub(sb8), .out_valid(ov8), .out_ready(or8), .out_sum(s8), .out_cout(c8),
      .out_ovf(o8), .out_zero(z8), .out_neg(n8));

   addsub_pipe #(.W(16), .STAGES(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
      .in_sub(sb16), .out_valid(ov16), .out_ready(or16), .out_sum(s16), .out_cout(c16),
      .out_ovf(o16), .out_zero(z16), .out_neg(n16));

   addsub_pipe #(.W(4), .STAGES(1)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
      .in_sub(sb4), .out_valid(ov4), .out_ready(or4), .out_sum(s4), .out_cout(c4),
      .out_ovf(o4), .out_zero(z4), .out_neg(n4));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // flags packed as {cout, ovf, zero, neg}
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [7:0] esum, input logic [3:0] eflg);
      @(negedge clk);
      a8 = a; b8 = b; sb8 = sub; iv8 = 1'b1;
      chk("u8 in_ready", ir8, 1'b1);
      @(posedge clk);
      #1 iv8 = 1'b0;
      @(negedge clk);
      chk("u8 valid after 1 cycle", ov8, 1'b0);
      @(negedge clk);
      chk("u8 valid after 2 cycles", ov8, 1'b1);
      chk("u8 sum", s8, esum);
      chk("u8 flags", {c8, o8, z8, n8}, eflg);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic sub);
      logic [4:0] f;
      logic [3:0] s;
      logic       ov;
      f  = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      s  = f[3:0];
      ov = sub ? (a[3] != b[3] && s[3] != a[3]) : (a[3] == b[3] && s[3] != a[3]);
      return {s, f[4], ov, (s == 4'h0), s[3]};
   endfunction

   logic [15:0] va[6], vb[6], es[6];
   logic        vs[6];
   logic [3:0]  ef[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int idx, oidx, lat, first_cyc, last_cyc, cyc;
      logic acc_now;
      logic [7:0] q4[$];
      logic [7:0] e4;
      int emitted4;

      va[0] = 16'h1234; vb[0] = 16'h1111; vs[0] = 1'b0; es[0] = 16'h2345; ef[0] = 4'b0000;
      va[1] = 16'h8000; vb[1] = 16'h0001; vs[1] = 1'b1; es[1] = 16'h7FFF; ef[1] = 4'b0100;
      va[2] = 16'h0003; vb[2] = 16'h0005; vs[2] = 1'b1; es[2] = 16'hFFFE; ef[2] = 4'b1001;
      va[3] = 16'h7FFF; vb[3] = 16'h0001; vs[3] = 1'b0; es[3] = 16'h8000; ef[3] = 4'b0101;
      va[4] = 16'hFFFF; vb[4] = 16'hFFFF; vs[4] = 1'b0; es[4] = 16'hFFFE; ef[4] = 4'b1001;
      va[5] = 16'hABCD; vb[5] = 16'hABCD; vs[5] = 1'b1; es[5] = 16'h0000; ef[5] = 4'b0010;

      rst = 1'b1;
      iv8 = 0; a8 = 0; b8 = 0; sb8 = 0; or8 = 1;
      iv16 = 0; a16 = 0; b16 = 0; sb16 = 0; or16 = 0;
      iv4 = 0; a4 = 0; b4 = 0; sb4 = 0; or4 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset u8 out_valid", ov8, 1'b0);
      chk("reset u8 out_sum", s8, 8'h00);
      chk("reset u8 flags", {c8, o8, z8, n8}, 4'b0000);
      chk("reset u16 out_valid", ov16, 1'b0);
      chk("reset u16 out_sum/flags", {s16, c16, o16, z16, n16}, 20'h0);
      chk("reset u4 out_valid/sum/flags", {ov4, s4, c4, o4, z4, n4}, 9'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("u8 in_ready after reset", ir8, 1'b1);
      chk("u16 in_ready after reset", ir16, 1'b1);

      // 8-bit directed vectors
      send8(8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101);
      send8(8'h05, 8'h07, 1'b1, 8'hFE, 4'b1001);
      send8(8'h80, 8'h01, 1'b1, 8'h7F, 4'b0100);
      send8(8'h10, 8'h10, 1'b1, 8'h00, 4'b0010);
      send8(8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010);

      // 16-bit backpressure: fill with out_ready low
      @(posedge clk);
      #1;
      idx = 0;
      or16 = 1'b0;
      a16 = va[0]; b16 = vb[0]; sb16 = vs[0]; iv16 = 1'b1;
      repeat (8) begin
         @(negedge clk);
         acc_now = iv16 && ir16;
         @(posedge clk);
         if (acc_now) idx++;
         #1;
         if (idx < 6) begin
            a16 = va[idx]; b16 = vb[idx]; sb16 = vs[idx]; iv16 = 1'b1;
         end else iv16 = 1'b0;
      end
      @(negedge clk);
      chk("u16 accepts while blocked", idx, 4);
      chk("u16 in_ready when full", ir16, 1'b0);
      chk("u16 held valid", ov16, 1'b1);
      chk("u16 held result", {s16, c16, o16, z16, n16}, {es[0], ef[0]});
      repeat (3) @(negedge clk);
      chk("u16 held result later", {s16, c16, o16, z16, n16}, {es[0], ef[0]});

      // release backpressure and drain
      @(posedge clk);
      #1 or16 = 1'b1;
      oidx = 0; first_cyc = -1; last_cyc = -1; cyc = 0;
      while (oidx < 6 && cyc < 20) begin
         @(negedge clk);
         acc_now = iv16 && ir16;
         if (ov16 && or16) begin
            chk($sformatf("u16 drain result %0d", oidx), {s16, c16, o16, z16, n16},
                {es[oidx], ef[oidx]});
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            oidx++;
         end
         @(posedge clk);
         if (acc_now) idx++;
         #1;
         if (idx < 6) begin
            a16 = va[idx]; b16 = vb[idx]; sb16 = vs[idx]; iv16 = 1'b1;
         end else iv16 = 1'b0;
         cyc++;
      end
      chk("u16 drain count", oidx, 6);
      chk("u16 one result per cycle", last_cyc - first_cyc, 5);

      // reset with three transactions in flight
      @(negedge clk);
      or16 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a16 = va[i]; b16 = vb[i]; sb16 = vs[i]; iv16 = 1'b1;
         @(posedge clk);
         #1;
      end
      iv16 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("u16 valid before reset", ov16, 1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("u16 valid right after async reset", ov16, 1'b0);
      chk("u16 sum right after async reset", s16, 16'h0000);
      @(posedge clk);
      #3 rst = 1'b0;
      or16 = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("u16 no stale output", ov16, 1'b0);
      end
      a16 = 16'hFFFF; b16 = 16'h0001; sb16 = 1'b0; iv16 = 1'b1;
      @(posedge clk);
      #1 iv16 = 1'b0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (ov16) break;
      end
      chk("u16 latency after reset", lat, 4);
      chk("u16 FFFF+0001", {s16, c16, o16, z16, n16}, {16'h0000, 4'b1010});

      // 4-bit single stage, random stream against a reference queue
      @(posedge clk);
      #1;
      emitted4 = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         chk("u4 in_ready rule", ir4, !ov4 || or4);
         if (iv4 && ir4) q4.push_back(model4(a4, b4, sb4));
         if (ov4 && or4) begin
            chk("u4 output without input", q4.size() == 0, 1'b0);
            if (q4.size() != 0) begin
               e4 = q4.pop_front();
               chk("u4 result", {s4, c4, o4, z4, n4}, e4);
               emitted4++;
            end
         end
         @(posedge clk);
         #1;
         if (c < 250) begin
            iv4 = 1'($urandom_range(0, 1));
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            sb4 = 1'($urandom_range(0, 1));
         end else iv4 = 1'b0;
         or4 = ($urandom_range(0, 3) != 0);
      end
      chk("u4 all results drained", q4.size(), 0);
      chk("u4 produced results", emitted4 > 50, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
